// File: rtl/chicken_pkg.sv
// Shared constants, state encoding and tile/player helpers for the turn controller.
package chicken_pkg;

  localparam int TILES       = 24;
  localparam int SYMS        = 12;
  localparam int MAX_PLAYERS = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT,
    ST_SEEK,
    ST_WAIT_PICK,
    ST_CHECK,
    ST_RESULT,
    ST_NEXT,
    ST_GAME_OVER
  } state_e;

  // Start-position table indexed by active player count and player index.
  function automatic logic [4:0] start_pos(input logic [2:0] n_act, input logic [1:0] idx);
    logic [4:0] p;
    p = 5'd0;
    case (n_act)
      3'd3: case (idx)
              2'd1:    p = 5'd8;
              2'd2:    p = 5'd16;
              default: p = 5'd0;
            endcase
      3'd4: case (idx)
              2'd1:    p = 5'd6;
              2'd2:    p = 5'd12;
              2'd3:    p = 5'd18;
              default: p = 5'd0;
            endcase
      default: p = (idx == 2'd1) ? 5'd12 : 5'd0;
    endcase
    return p;
  endfunction

  function automatic logic [4:0] tile_inc(input logic [4:0] t);
    return (t == 5'(TILES - 1)) ? 5'd0 : t + 5'd1;
  endfunction

  function automatic logic [3:0] tile_sym(input logic [4:0] t);
    return (t >= 5'(SYMS)) ? 4'(t - 5'(SYMS)) : 4'(t);
  endfunction

  function automatic logic [2:0] clamp_players(input logic [2:0] n);
    logic [2:0] r;
    r = n;
    if (n < 3'd2) r = 3'd2;
    if (n > 3'd4) r = 3'd4;
    return r;
  endfunction

endpackage

// File: rtl/turn_controller_if.sv
// Game-side bus of the turn controller: player/control inputs and data_path handshake.
interface turn_controller_if;
  logic [2:0] N;
  logic       start;
  logic       pick_valid;
  logic [2:0] pick_card;
  logic [3:0] card_sym;
  logic       go;
  logic       W;
  logic [3:0] position_data;
  logic [3:0] card_data;
  logic       A;
  logic       statecombo_next_turn;
  logic [1:0] cur_player;
  logic [4:0] pos_tile;
  logic       pick_ready;
  logic       game_over;

  modport master (
    output N, start, pick_valid, pick_card, card_sym, go, W,
    input  position_data, card_data, A, statecombo_next_turn,
           cur_player, pos_tile, pick_ready, game_over
  );

  modport slave (
    input  N, start, pick_valid, pick_card, card_sym, go, W,
    output position_data, card_data, A, statecombo_next_turn,
           cur_player, pos_tile, pick_ready, game_over
  );
endinterface

// File: rtl/tile_occupied.sv
// Flags whether a target tile holds any active player other than the current one.
module tile_occupied
  import chicken_pkg::*;
(
  input  logic [4:0]                   target,
  input  logic [MAX_PLAYERS-1:0][4:0]  pos,
  input  logic [1:0]                   cur,
  input  logic [2:0]                   n_act,
  output logic                         occupied
);

  always_comb begin
    occupied = 1'b0;
    for (int i = 0; i < MAX_PLAYERS; i++) begin
      if ((3'(i) < n_act) && (2'(i) != cur) && (pos[i] == target)) occupied = 1'b1;
    end
  end

endmodule

// File: rtl/turn_controller.sv
// Turn sequencing for the 24-tile ring game; define TURN_TIMEOUT_EN to forfeit
// a turn after TIMEOUT_CYC cycles without a pick.
//
// state        | meaning
// ST_IDLE      | waiting for start
// ST_INIT      | load start positions, player 0 first
// ST_SEEK      | step target past tiles held by other players
// ST_WAIT_PICK | waiting for a card flip
// ST_CHECK     | data_path registers its comparison
// ST_RESULT    | sample go/W, move player on a match
// ST_NEXT      | advance to the next player
// ST_GAME_OVER | winner found, waiting for restart
module turn_controller
  import chicken_pkg::*;
#(
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic              clk,
  input  logic              rst,
  turn_controller_if.slave  bus
);

  state_e                        state_q, state_d;
  logic [1:0]                    cur_q, cur_d;
  logic [2:0]                    n_q, n_d;
  logic [MAX_PLAYERS-1:0][4:0]   pos_q, pos_d;
  logic [4:0]                    target_q, target_d;
  logic [3:0]                    pdata_q, pdata_d;
  logic [3:0]                    cdata_q, cdata_d;
  logic                          a_q, a_d;
  logic                          occupied;
  logic                          tmo_done;
  logic                          unused_pick;

  assign unused_pick = ^bus.pick_card;

  tile_occupied u_occ (
    .target   (target_q),
    .pos      (pos_q),
    .cur      (cur_q),
    .n_act    (n_q),
    .occupied (occupied)
  );

`ifdef TURN_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TMO_W-1:0] tmo_q, tmo_d;

  assign tmo_done = (tmo_q == TMO_W'(TIMEOUT_CYC - 1));

  always_comb begin
    tmo_d = '0;
    if (state_q == ST_WAIT_PICK && state_d == ST_WAIT_PICK) tmo_d = tmo_q + TMO_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) tmo_q <= '0;
    else     tmo_q <= tmo_d;
  end
`else
  localparam int unused_timeout = TIMEOUT_CYC;
  assign tmo_done = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    cur_d    = cur_q;
    n_d      = n_q;
    pos_d    = pos_q;
    target_d = target_q;
    pdata_d  = pdata_q;
    cdata_d  = cdata_q;
    a_d      = 1'b0;
    case (state_q)
      ST_IDLE, ST_GAME_OVER: begin
        if (bus.start) begin
          n_d     = clamp_players(bus.N);
          state_d = ST_INIT;
        end
      end
      ST_INIT: begin
        for (int i = 0; i < MAX_PLAYERS; i++) pos_d[i] = start_pos(n_q, 2'(i));
        cur_d    = 2'd0;
        target_d = tile_inc(start_pos(n_q, 2'd0));
        state_d  = ST_SEEK;
      end
      ST_SEEK: begin
        if (occupied) target_d = tile_inc(target_q);
        else          state_d  = ST_WAIT_PICK;
      end
      ST_WAIT_PICK: begin
        if (bus.pick_valid) begin
          cdata_d = bus.card_sym;
          pdata_d = tile_sym(target_q);
          a_d     = 1'b1;
          state_d = ST_CHECK;
        end else if (tmo_done) begin
          state_d = ST_NEXT;
        end
      end
      ST_CHECK: state_d = ST_RESULT;
      ST_RESULT: begin
        if (bus.go) pos_d[cur_q] = target_q;
        if (bus.W) begin
          state_d = ST_GAME_OVER;
        end else if (bus.go) begin
          target_d = tile_inc(target_q);
          state_d  = ST_SEEK;
        end else begin
          state_d = ST_NEXT;
        end
      end
      ST_NEXT: begin
        cur_d    = (cur_q == 2'(n_q - 3'd1)) ? 2'd0 : cur_q + 2'd1;
        target_d = tile_inc(pos_q[cur_d]);
        state_d  = ST_SEEK;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cur_q    <= 2'd0;
      n_q      <= 3'd2;
      pos_q    <= '0;
      target_q <= 5'd0;
      pdata_q  <= 4'd0;
      cdata_q  <= 4'd0;
      a_q      <= 1'b0;
    end else begin
      state_q  <= state_d;
      cur_q    <= cur_d;
      n_q      <= n_d;
      pos_q    <= pos_d;
      target_q <= target_d;
      pdata_q  <= pdata_d;
      cdata_q  <= cdata_d;
      a_q      <= a_d;
    end
  end

  assign bus.A                    = a_q;
  assign bus.position_data        = pdata_q;
  assign bus.card_data            = cdata_q;
  assign bus.statecombo_next_turn = (state_q == ST_NEXT);
  assign bus.cur_player           = cur_q;
  assign bus.pos_tile             = pos_q[cur_q];
  assign bus.pick_ready           = (state_q == ST_WAIT_PICK);
  assign bus.game_over            = (state_q == ST_GAME_OVER);

endmodule

// File: tb/tb_turn_controller.sv
// Directed bench for turn_controller; the forfeit case runs when TURN_TIMEOUT_EN is defined.
module tb_turn_controller;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  turn_controller_if ifc();

  turn_controller #(.TIMEOUT_CYC(1000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.slave)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int a_count  = 0;
  int nt_count = 0;

  always @(posedge clk) begin
    if (ifc.A === 1'b1) a_count <= a_count + 1;
    if (ifc.statecombo_next_turn === 1'b1) nt_count <= nt_count + 1;
  end

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string tag);
    int k = 0;
    while (ifc.pick_ready !== 1'b1 && k < 100) begin
      tick();
      k++;
    end
    if (ifc.pick_ready !== 1'b1) check({tag, "_ready_timeout"}, int'(ifc.pick_ready), 1);
  endtask

  // One full turn: flip a card, present go/W through RESULT.
  task automatic turn(input logic [3:0] sym, input logic g, input logic w,
                      output int pd, output int cd);
    wait_ready("turn");
    ifc.pick_valid = 1'b1;
    ifc.pick_card  = 3'd2;
    ifc.card_sym   = sym;
    ifc.go         = g;
    ifc.W          = w;
    tick();
    pd = int'(ifc.position_data);
    cd = int'(ifc.card_data);
    ifc.pick_valid = 1'b0;
    tick();
    tick();
    ifc.go = 1'b0;
    ifc.W  = 1'b0;
  endtask

  task automatic new_game(input logic [2:0] n);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ifc.N     = n;
    ifc.start = 1'b1;
    tick();
    ifc.start = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_A"},          int'(ifc.A), 0);
    check({tag, "_next_turn"},  int'(ifc.statecombo_next_turn), 0);
    check({tag, "_pick_ready"}, int'(ifc.pick_ready), 0);
    check({tag, "_game_over"},  int'(ifc.game_over), 0);
    check({tag, "_cur_player"}, int'(ifc.cur_player), 0);
    check({tag, "_pos_data"},   int'(ifc.position_data), 0);
    check({tag, "_card_data"},  int'(ifc.card_data), 0);
    check({tag, "_pos_tile"},   int'(ifc.pos_tile), 0);
  endtask

  initial begin
    int pd, cd, a0, nt0;
    ifc.N = 3'd2;
    ifc.start = 1'b0;
    ifc.pick_valid = 1'b0;
    ifc.pick_card = 3'd0;
    ifc.card_sym = 4'd0;
    ifc.go = 1'b0;
    ifc.W = 1'b0;
    tick();
    tick();
    check_all_zero("reset");

    // Picks and results outside their states must do nothing.
    rst = 1'b0;
    a0 = a_count;
    ifc.pick_valid = 1'b1;
    ifc.go = 1'b1;
    ifc.W = 1'b1;
    tick();
    tick();
    ifc.pick_valid = 1'b0;
    ifc.go = 1'b0;
    ifc.W = 1'b0;
    check("idle_pick_ignored", a_count - a0, 0);
    check("idle_w_ignored", int'(ifc.game_over), 0);

    // Match keeps the same player.
    new_game(3'd2);
    a0 = a_count;
    nt0 = nt_count;
    turn(4'd1, 1'b1, 1'b0, pd, cd);
    check("match_pos_data", pd, 1);
    check("match_card_data", cd, 1);
    check("match_a_pulses", a_count - a0, 1);
    check("match_pos_tile", int'(ifc.pos_tile), 1);
    check("match_cur_player", int'(ifc.cur_player), 0);
    check("match_no_next", nt_count - nt0, 0);

    // Miss hands the turn to player 1.
    new_game(3'd2);
    nt0 = nt_count;
    turn(4'd7, 1'b0, 1'b0, pd, cd);
    check("miss_card_data", cd, 7);
    check("miss_pos_data", pd, 1);
    wait_ready("miss");
    check("miss_next_pulses", nt_count - nt0, 1);
    check("miss_cur_player", int'(ifc.cur_player), 1);
    check("miss_pos_tile", int'(ifc.pos_tile), 12);

    ifc.go = 1'b1;
    ifc.W = 1'b1;
    tick();
    tick();
    tick();
    check("wait_w_ignored", int'(ifc.game_over), 0);
    check("wait_still_ready", int'(ifc.pick_ready), 1);
    check("wait_go_ignored", int'(ifc.pos_tile), 12);
    ifc.go = 1'b0;
    ifc.W = 1'b0;

    // Player 0 to tile 5, player 1 to tile 23, then wrap.
    turn(4'd0, 1'b0, 1'b0, pd, cd);
    for (int i = 0; i < 5; i++) turn(4'd0, 1'b1, 1'b0, pd, cd);
    turn(4'd0, 1'b0, 1'b0, pd, cd);
    for (int i = 0; i < 11; i++) turn(4'd0, 1'b1, 1'b0, pd, cd);
    wait_ready("wrap");
    check("wrap_pre_pos_tile", int'(ifc.pos_tile), 23);
    check("wrap_pre_cur", int'(ifc.cur_player), 1);
    turn(4'd0, 1'b1, 1'b0, pd, cd);
    check("wrap_pos_data", pd, 0);
    wait_ready("wrap2");
    check("wrap_pos_tile", int'(ifc.pos_tile), 0);

    // Four players: skip occupied tile 6, then win.
    new_game(3'd4);
    for (int i = 0; i < 5; i++) begin
      turn(4'd0, 1'b1, 1'b0, pd, cd);
      check("walk_pos_data", pd, i + 1);
    end
    wait_ready("skip");
    check("skip_pre_pos_tile", int'(ifc.pos_tile), 5);
    turn(4'd3, 1'b1, 1'b1, pd, cd);
    check("skip_pos_data", pd, 7);
    check("win_game_over", int'(ifc.game_over), 1);
    check("win_pick_ready", int'(ifc.pick_ready), 0);
    check("win_pos_tile", int'(ifc.pos_tile), 7);

    // Restart from GAME_OVER with two players.
    ifc.N = 3'd2;
    ifc.start = 1'b1;
    tick();
    ifc.start = 1'b0;
    check("restart_game_over", int'(ifc.game_over), 0);
    tick();
    check("restart_p0_tile", int'(ifc.pos_tile), 0);
    check("restart_cur", int'(ifc.cur_player), 0);
    turn(4'd0, 1'b0, 1'b0, pd, cd);
    wait_ready("restart");
    check("restart_p1_tile", int'(ifc.pos_tile), 12);

    // Player-count clamping.
    new_game(3'd0);
    turn(4'd0, 1'b0, 1'b0, pd, cd);
    wait_ready("clamp_lo");
    check("clamp_lo_tile", int'(ifc.pos_tile), 12);
    turn(4'd0, 1'b0, 1'b0, pd, cd);
    wait_ready("clamp_lo2");
    check("clamp_lo_wrap_cur", int'(ifc.cur_player), 0);
    new_game(3'd7);
    turn(4'd0, 1'b0, 1'b0, pd, cd);
    wait_ready("clamp_hi");
    check("clamp_hi_tile", int'(ifc.pos_tile), 6);

    // Reset while in CHECK.
    new_game(3'd2);
    wait_ready("rst_check");
    ifc.pick_valid = 1'b1;
    ifc.card_sym = 4'd9;
    tick();
    ifc.pick_valid = 1'b0;
    check("rst_check_A_high", int'(ifc.A), 1);
    check("rst_check_card", int'(ifc.card_data), 9);
    rst = 1'b1;
    tick();
    check_all_zero("rst_check");
    rst = 1'b0;

`ifdef TURN_TIMEOUT_EN
    begin
      int cnt = 0;
      new_game(3'd2);
      wait_ready("tmo");
      a0 = a_count;
      nt0 = nt_count;
      while (ifc.pick_ready === 1'b1 && cnt < 1100) begin
        cnt++;
        tick();
      end
      check("tmo_wait_cycles", cnt, 1000);
      check("tmo_next_pulse_now", int'(ifc.statecombo_next_turn), 1);
      tick();
      check("tmo_next_pulses", nt_count - nt0, 1);
      check("tmo_no_A", a_count - a0, 0);
      check("tmo_cur_player", int'(ifc.cur_player), 1);
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
